bcd_seg_scan: RTL and testbench

//   Downstream display stage for the BCD counter. Captures each BCD digit the

---
 rtl/bcd_seg_scan.sv | 98 +++++++++
 tb/tb_bcd_seg_scan.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - BCD digit capture shift register with multiplexed 7-segment scan.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module bcd_seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 4
) (
  input  logic                    clk,
  input  logic                    rst_asyn,
  input  logic [3:0]              bcd_in,
  input  logic                    bcd_valid,
  input  logic                    clr,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    err,
  output logic [4*NUM_DIGITS-1:0] digits
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div;
  logic [IDX_W-1:0] idx;
  logic [3:0]       cur_digit;
  logic             blank;
  logic [6:0]       seg_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  // Codes above 9 never enter the shift register; they only latch err.
  always_ff @(posedge clk or negedge rst_asyn) begin
    if (!rst_asyn) begin
      digits <= '0;
      err    <= 1'b0;
    end else if (clr) begin
      digits <= '0;
      err    <= 1'b0;
    end else if (bcd_valid) begin
      if (bcd_in > 4'd9)
        err <= 1'b1;
      else
        digits <= {digits[4*NUM_DIGITS-5:0], bcd_in};
    end
  end

  always_ff @(posedge clk or negedge rst_asyn) begin
    if (!rst_asyn) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign cur_digit = digits[4*idx +: 4];

  // Blank when no stored digit at or above the scanned position is nonzero.
  always_comb begin
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(idx) <= i && digits[4*i +: 4] != 4'd0)
        blank = 1'b0;
    end
`endif
    seg_next = blank ? 7'h00 : decode(cur_digit);
  end

  always_ff @(posedge clk or negedge rst_asyn) begin
    if (!rst_asyn) begin
      an  <= '0;
      seg <= 7'h00;
    end else begin
      an  <= NUM_DIGITS'(1) << idx;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb/tb_bcd_seg_scan.sv - directed self-checking bench for bcd_seg_scan (4 digits, divide by 4).
module tb_bcd_seg_scan;

  logic        clk = 1'b0;
  logic        rst_asyn;
  logic [3:0]  bcd_in;
  logic        bcd_valid;
  logic        clr;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        err;
  logic [15:0] digits;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [15:0] exp_d;

  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_asyn(rst_asyn), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .clr(clr), .seg(seg), .an(an), .err(err), .digits(digits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] d, input int i);
    logic [3:0]  v;
    logic [15:0] upper;
    v = d[4*i +: 4];
    upper = d >> (4*i);
`ifdef LEADING_ZERO_BLANK_EN
    if (i != 0 && upper == 16'h0) return 7'h00;
`endif
    return SEG_TAB[v];
  endfunction

  // Scan output after edge k (counted from reset release) reflects idx before that edge.
  task automatic scan_check(input string tag, input int n);
    int i;
    for (int k = 0; k < n; k++) begin
      tick();
      i = ((cyc - 1) / 4) % 4;
      check({tag, "_an"}, 32'(an), 32'(4'b0001 << i));
      check({tag, "_seg"}, 32'(seg), 32'(exp_seg(exp_d, i)));
    end
  endtask

  task automatic strobe(input logic [3:0] v);
    bcd_in    = v;
    bcd_valid = 1'b1;
    tick();
    bcd_valid = 1'b0;
  endtask

  initial begin
    rst_asyn  = 1'b0;
    bcd_in    = 4'd0;
    bcd_valid = 1'b0;
    clr       = 1'b0;
    exp_d     = 16'h0;
    #2;
    check("rst_an", 32'(an), 32'h0);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst_asyn = 1'b1;
    cyc = 0;
    scan_check("post_rst", 5);

    strobe(4'd1);
    strobe(4'd2);
    strobe(4'd3);
    strobe(4'd4);
    exp_d = 16'h1234;
    check("shift_digits", 32'(digits), 32'h1234);
    scan_check("scan_1234", 20);

    strobe(4'd5);
    exp_d = 16'h2345;
    check("overflow_digits", 32'(digits), 32'h2345);

    strobe(4'hA);
    check("bad_digits", 32'(digits), 32'h2345);
    check("bad_err", 32'(err), 32'h1);
    tick();
    tick();
    check("bad_err_held", 32'(err), 32'h1);
    check("bad_digits_held", 32'(digits), 32'h2345);

    clr = 1'b1;
    strobe(4'd7);
    clr = 1'b0;
    exp_d = 16'h0;
    check("clr_digits", 32'(digits), 32'h0);
    check("clr_err", 32'(err), 32'h0);

    while (cyc % 16 != 0) tick();
    strobe(4'd8);
    check("coll_an", 32'(an), 32'h1);
    check("coll_seg_old", 32'(seg), 32'h3F);
    tick();
    check("coll_seg_new", 32'(seg), 32'h7F);
    check("coll_digits", 32'(digits), 32'h0008);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    strobe(4'd7);
    strobe(4'd0);
    exp_d = 16'h0070;
    check("blank_digits", 32'(digits), 32'h0070);
    scan_check("blank_scan", 16);

    strobe(4'hB);
    tick();
    rst_asyn = 1'b0;
    #1;
    check("midrst_an", 32'(an), 32'h0);
    check("midrst_seg", 32'(seg), 32'h0);
    check("midrst_digits", 32'(digits), 32'h0);
    check("midrst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst_asyn = 1'b1;
    cyc = 0;
    exp_d = 16'h0;
    scan_check("midrst_scan", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
